// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: increment step,
// branch predictor counter encodings and their saturating update helpers.
package pc_gen_pkg;

   localparam int unsigned PC_INC = 4;

   typedef enum logic [1:0] {
      CTR_SNT = 2'd0,
      CTR_WNT = 2'd1,
      CTR_WT  = 2'd2,
      CTR_ST  = 2'd3
   } ctr_e;

   function automatic ctr_e ctr_inc(input ctr_e c);
      ctr_e r;
      case (c)
         CTR_SNT: r = CTR_WNT;
         CTR_WNT: r = CTR_WT;
         default: r = CTR_ST;
      endcase
      return r;
   endfunction

   function automatic ctr_e ctr_dec(input ctr_e c);
      ctr_e r;
      case (c)
         CTR_ST:  r = CTR_WT;
         CTR_WT:  r = CTR_WNT;
         default: r = CTR_SNT;
      endcase
      return r;
   endfunction

   function automatic logic ctr_taken(input ctr_e c);
      return (c == CTR_WT) || (c == CTR_ST);
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Bundle between the PC register/mux and the branch target buffer.
// Addresses travel as word addresses (bits [XLEN-1:2]); the byte offset is always zero.
interface pc_gen_if #(
   parameter int XLEN = 32
);
   // update_en qualifies update_* for exactly one cycle; there is no back-pressure,
   // the BTB always accepts. Lookup is purely combinational on lookup_pc.
   logic            update_en;
   logic [XLEN-1:2] update_pc;
   logic [XLEN-1:2] update_target;
   logic            update_taken;
   logic [XLEN-1:2] lookup_pc;
   logic            pred_taken;
   logic [XLEN-1:2] pred_target;

   modport master (
      output update_en, update_pc, update_target, update_taken, lookup_pc,
      input  pred_taken, pred_target
   );

   modport slave (
      input  update_en, update_pc, update_target, update_taken, lookup_pc,
      output pred_taken, pred_target
   );
endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Writes land on the clock edge, so a same-cycle lookup observes the old entry.
module pc_gen_btb
   import pc_gen_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BTB_ENTRIES = 16
) (
   input logic   clk,
   input logic   rst,
   pc_gen_if.slave btb
);
   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX - 2;

   logic [BTB_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
   logic [XLEN-1:2]        target_q [BTB_ENTRIES];
   ctr_e                   ctr_q    [BTB_ENTRIES];

   logic [IDX-1:0]   lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [IDX-1:0]   up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;

   assign lk_idx = btb.lookup_pc[IDX+1:2];
   assign lk_tag = btb.lookup_pc[XLEN-1:IDX+2];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

   assign btb.pred_taken  = lk_hit && ctr_taken(ctr_q[lk_idx]);
   assign btb.pred_target = target_q[lk_idx];

   assign up_idx = btb.update_pc[IDX+1:2];
   assign up_tag = btb.update_pc[XLEN-1:IDX+2];
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // Tag/target/counter arrays are only meaningful under valid, so only valid is reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (btb.update_en) begin
         if (btb.update_taken) begin
            target_q[up_idx] <= btb.update_target;
            if (up_hit) begin
               ctr_q[up_idx] <= ctr_inc(ctr_q[up_idx]);
            end else begin
               valid_q[up_idx] <= 1'b1;
               tag_q[up_idx]   <= up_tag;
               ctr_q[up_idx]   <= CTR_WT;
            end
         end else if (up_hit) begin
            ctr_q[up_idx] <= ctr_dec(ctr_q[up_idx]);
         end
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register and next-PC selection: reset, execute correction, stall,
// BTB prediction or sequential increment, in that priority order.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              BTB_ENTRIES  = 16
) (
   input  logic            clock_in,
   input  logic            reset_in,
   input  logic            pc_gen_stall_in,
   input  logic            pc_gen_correction_en_in,
   input  logic [XLEN-1:0] pc_gen_correction_in,
   input  logic            pc_gen_update_en_in,
   input  logic [XLEN-1:0] pc_gen_update_pc_in,
   input  logic [XLEN-1:0] pc_gen_update_target_in,
   input  logic            pc_gen_update_taken_in,
   output logic [XLEN-1:0] pc_gen_pc_out,
   output logic            pc_gen_pred_out
);
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pred_q, pred_d;
   logic            unused_low;

   pc_gen_if #(.XLEN(XLEN)) btb_if ();

   pc_gen_btb #(
      .XLEN        (XLEN),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk (clock_in),
      .rst (reset_in),
      .btb (btb_if.slave)
   );

   assign btb_if.update_en     = pc_gen_update_en_in;
   assign btb_if.update_pc     = pc_gen_update_pc_in[XLEN-1:2];
   assign btb_if.update_target = pc_gen_update_target_in[XLEN-1:2];
   assign btb_if.update_taken  = pc_gen_update_taken_in;
   assign btb_if.lookup_pc     = pc_q[XLEN-1:2];

   // Byte offsets of loaded addresses are dropped, so these bits have no consumer.
   assign unused_low = ^{pc_gen_correction_in[1:0], pc_gen_update_pc_in[1:0],
                         pc_gen_update_target_in[1:0]};

   always_comb begin
      pc_d   = pc_q;
      pred_d = pred_q;
      if (pc_gen_correction_en_in) begin
         pc_d   = {pc_gen_correction_in[XLEN-1:2], 2'b00};
         pred_d = 1'b0;
      end else if (pc_gen_stall_in) begin
         pc_d   = pc_q;
         pred_d = pred_q;
      end else if (btb_if.pred_taken) begin
         pc_d   = {btb_if.pred_target, 2'b00};
         pred_d = 1'b1;
      end else begin
         pc_d   = pc_q + XLEN'(PC_INC);
         pred_d = 1'b0;
      end
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         pc_q   <= RESET_VECTOR;
         pred_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         pred_q <= pred_d;
      end
   end

   assign pc_gen_pc_out   = pc_q;
   assign pc_gen_pred_out = pred_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: the driver queues the expected PC/prediction per cycle,
// and an independent monitor pops and compares against the registered outputs.
module tb_pc_gen;
   localparam int          XLEN = 32;
   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam int          W    = 49;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        corr_en;
   logic [31:0] corr;
   logic [1:0]  upd_pc_lo;
   logic [1:0]  upd_tgt_lo;
   logic [31:0] pc;
   logic        pred;

   pc_gen_if #(.XLEN(XLEN)) stim_if ();

   assign stim_if.lookup_pc   = '0;
   assign stim_if.pred_taken  = 1'b0;
   assign stim_if.pred_target = '0;

   pc_gen #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RV),
      .BTB_ENTRIES  (16)
   ) dut (
      .clock_in                (clk),
      .reset_in                (rst),
      .pc_gen_stall_in         (stall),
      .pc_gen_correction_en_in (corr_en),
      .pc_gen_correction_in    (corr),
      .pc_gen_update_en_in     (stim_if.update_en),
      .pc_gen_update_pc_in     ({stim_if.update_pc, upd_pc_lo}),
      .pc_gen_update_target_in ({stim_if.update_target, upd_tgt_lo}),
      .pc_gen_update_taken_in  (stim_if.update_taken),
      .pc_gen_pc_out           (pc),
      .pc_gen_pred_out         (pred)
   );

   // clock / cycle counter
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // scoreboard: {cycle tag[15:0], pred, pc[31:0]}
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_e;
   int checks = 0;
   int errors = 0;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q[0];
         if (mon_e[48:33] == 16'(cyc_cnt)) begin
            void'(exp_q.pop_front());
            checks++;
            if (pc !== mon_e[31:0] || pred !== mon_e[32]) begin
               errors++;
               $display("FAIL pc_pred cycle %0d: got pc=%h pred=%b, expected pc=%h pred=%b",
                        cyc_cnt, pc, pred, mon_e[31:0], mon_e[32]);
            end
         end else if (mon_e[48:33] < 16'(cyc_cnt)) begin
            void'(exp_q.pop_front());
            checks++;
            errors++;
            $display("FAIL missed_sample cycle %0d: expected pc=%h pred=%b never compared",
                     mon_e[48:33], mon_e[31:0], mon_e[32]);
         end
      end
   end

   // driver tasks
   task automatic clear_inputs();
      rst                  = 1'b0;
      stall                = 1'b0;
      corr_en              = 1'b0;
      corr                 = '0;
      stim_if.update_en    = 1'b0;
      stim_if.update_pc    = '0;
      stim_if.update_target = '0;
      stim_if.update_taken = 1'b0;
      upd_pc_lo            = 2'b00;
      upd_tgt_lo           = 2'b00;
   endtask

   task automatic tick(input logic [31:0] e_pc, input logic e_pred);
      logic [15:0] tag;
      tag = 16'(cyc_cnt + 1);
      exp_q.push_back({tag, e_pred, e_pc});
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
      stim_if.update_en     = 1'b1;
      stim_if.update_pc     = p[31:2];
      upd_pc_lo             = p[1:0];
      stim_if.update_target = t[31:2];
      upd_tgt_lo            = t[1:0];
      stim_if.update_taken  = tk;
   endtask

   task automatic redirect(input logic [31:0] a);
      corr_en = 1'b1;
      corr    = a;
   endtask

   initial begin
      clear_inputs();

      // reset state, then sequential fetch from an empty BTB
      rst = 1'b1; tick(RV, 1'b0);
      rst = 1'b1; tick(RV, 1'b0);
      tick(32'h4, 1'b0);
      tick(32'h8, 1'b0);
      tick(32'hC, 1'b0);

      // allocate 0x8 -> 0x40 while fetching from 0, prediction seen only on 0x40
      rst = 1'b1; tick(RV, 1'b0);
      upd(32'h8, 32'h40, 1'b1); tick(32'h4, 1'b0);
      tick(32'h8, 1'b0);
      tick(32'h40, 1'b1);
      tick(32'h44, 1'b0);

      // counter 2 -> 3 -> 2 -> 1; fetch of 0x48 aliases index of 0x8 but misses on tag
      upd(32'h8, 32'h40, 1'b1); tick(32'h48, 1'b0);
      upd(32'h8, 32'h0, 1'b0);  tick(32'h4C, 1'b0);
      upd(32'h8, 32'h0, 1'b0);  tick(32'h50, 1'b0);
      redirect(32'h8);          tick(32'h8, 1'b0);
      tick(32'hC, 1'b0);
      tick(32'h10, 1'b0);

      // stall at 0x10 for three cycles, correction in the second wins
      stall = 1'b1; tick(32'h10, 1'b0);
      stall = 1'b1; redirect(32'h200); tick(32'h200, 1'b0);
      stall = 1'b1; tick(32'h200, 1'b0);
      tick(32'h204, 1'b0);

      // counter 1 -> 2 with unaligned target; prediction flag held through a stall
      upd(32'h8, 32'h43, 1'b1); tick(32'h208, 1'b0);
      redirect(32'h8);          tick(32'h8, 1'b0);
      tick(32'h40, 1'b1);
      stall = 1'b1; tick(32'h40, 1'b1);
      tick(32'h44, 1'b0);

      // unaligned correction is word aligned
      redirect(32'h103); tick(32'h100, 1'b0);

      // same-cycle update at the fetched PC is not seen until the next cycle
      redirect(32'h80); tick(32'h80, 1'b0);
      tick(32'h84, 1'b0);
      upd(32'h84, 32'h20, 1'b1); tick(32'h88, 1'b0);
      redirect(32'h84); tick(32'h84, 1'b0);
      tick(32'h20, 1'b1);

      // wrap past the top of the address space
      redirect(32'hFFFF_FFFC); tick(32'hFFFF_FFFC, 1'b0);
      tick(32'h0, 1'b0);
      tick(32'h4, 1'b0);

      // reset beats correction and update; BTB is empty afterwards
      rst = 1'b1; redirect(32'h300); upd(32'h100, 32'h500, 1'b1); tick(RV, 1'b0);
      tick(32'h4, 1'b0);
      tick(32'h8, 1'b0);
      tick(32'hC, 1'b0);
      redirect(32'h100); tick(32'h100, 1'b0);
      tick(32'h104, 1'b0);

      // drain with a bounded wait
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached with %0d entries pending", exp_q.size());
      $fatal(1, "watchdog");
   end

endmodule
